// File: rtl/div_unit_seq.sv
// div_unit_seq: handshaked radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Special cases resolve in one cycle. CALC runs once per significant dividend bit.
module div_unit_seq #(
   parameter int WIDTH     = 32,
   parameter int TAG_W     = 5,
   parameter int EARLY_OUT = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [TAG_W-1:0] tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_dbz
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_n;

   logic [CW-1:0]    cnt, n_it;
   logic [WIDTH-1:0] acc, quo, dvd, mb, ma_in, mb_in, fast_res, quo_n, rem_n, res_n;
   logic [WIDTH:0]   acc_sh, diff;
   logic             rem_op, qneg, rneg, sgn_a, sgn_b, accept, fast, ovf, ge, last;

   assign in_ready  = state == IDLE && !rst;
   assign out_valid = state == DONE;
   assign accept    = in_valid && in_ready && !flush;
   assign sgn_a     = !op[0] && a[WIDTH-1];
   assign sgn_b     = !op[0] && b[WIDTH-1];
   assign ma_in     = sgn_a ? -a : a;
   assign mb_in     = sgn_b ? -b : b;
   assign ovf       = !op[0] && a == MIN && b == '1;
   assign fast      = b == '0 || ovf || mb_in > ma_in;
   assign fast_res  = b == '0 ? (op[1] ? a : '1) : ovf ? (op[1] ? '0 : MIN) : (op[1] ? a : '0);

   always_comb begin
      n_it = CW'(WIDTH);
      if (EARLY_OUT != 0)
         for (int i = 0; i < WIDTH; i++)
            if (ma_in[i]) n_it = CW'(i + 1);
   end

   // A borrow out of the trial subtraction means acc_sh < |b|.
   assign acc_sh = {acc, dvd[WIDTH-1]};
   assign diff   = acc_sh - {1'b0, mb};
   assign ge     = !diff[WIDTH];
   assign rem_n  = ge ? diff[WIDTH-1:0] : acc_sh[WIDTH-1:0];
   assign quo_n  = {quo[WIDTH-2:0], ge};
   assign res_n  = rem_op ? (rneg ? -rem_n : rem_n) : (qneg ? -quo_n : quo_n);
   assign last   = cnt == CW'(1);

   always_ff @(posedge clk)
      state <= rst ? IDLE : state_n;

   always_comb begin
      state_n = state;
      if (flush) state_n = IDLE;
      else if (state == IDLE) state_n = accept ? (fast ? DONE : CALC) : IDLE;
      else if (state == CALC) state_n = last ? DONE : CALC;
      else state_n = out_ready ? IDLE : DONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         acc        <= '0;
         quo        <= '0;
         dvd        <= '0;
         mb         <= '0;
         rem_op     <= 1'b0;
         qneg       <= 1'b0;
         rneg       <= 1'b0;
         out_result <= '0;
         out_tag    <= '0;
         out_dbz    <= 1'b0;
      end else if (accept) begin
         rem_op  <= op[1];
         qneg    <= sgn_a ^ sgn_b;
         rneg    <= sgn_a;
         mb      <= mb_in;
         dvd     <= ma_in << (CW'(WIDTH) - n_it);
         cnt     <= n_it;
         acc     <= '0;
         quo     <= '0;
         out_tag <= tag;
         out_dbz <= b == '0;
         if (fast) out_result <= fast_res;
      end else if (state == CALC) begin
         acc <= rem_n;
         quo <= quo_n;
         dvd <= dvd << 1;
         cnt <= cnt - CW'(1);
         if (last) out_result <= res_n;
      end
   end
endmodule

// File: tb/tb_div_unit_seq.sv
// tb_div_unit_seq: vector table, hand sequences for backpressure/flush/reset,
// and random operations checked against an arithmetic reference model.
module tb_div_unit_seq;
   logic        clk = 1'b0, rst, flush, in_valid, out_ready;
   logic        in_ready, out_valid, out_dbz;
   logic [1:0]  op;
   logic [31:0] a, b, out_result;
   logic [4:0]  tag, out_tag;
   int total = 0, bad = 0;

   always #5 clk = ~clk;

   div_unit_seq #(.WIDTH(32), .TAG_W(5), .EARLY_OUT(1)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .tag(tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_tag(out_tag), .out_dbz(out_dbz)
   );

   typedef struct {
      logic [1:0]  o;
      logic [31:0] x, y;
      logic [4:0]  t;
      logic [31:0] r;
      logic        d;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Reference: signed/unsigned truncating division in 64-bit arithmetic.
   function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] r, output logic d, output int lat);
      longint sx, sy, q, rm, mx, my;
      if (o[0]) begin
         sx = {32'b0, x};
         sy = {32'b0, y};
      end else begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end
      mx = sx < 0 ? -sx : sx;
      my = sy < 0 ? -sy : sy;
      d = y == 0;
      if (y == 0) begin
         r = o[1] ? x : 32'hFFFFFFFF;
         lat = 1;
      end else if (!o[0] && x == 32'h80000000 && y == 32'hFFFFFFFF) begin
         r = o[1] ? 32'h0 : 32'h80000000;
         lat = 1;
      end else begin
         q = sx / sy;
         rm = sx % sy;
         r = o[1] ? rm[31:0] : q[31:0];
         lat = my > mx ? 1 : $clog2(mx + 1) + 1;
      end
   endfunction

   task automatic run(input string nm, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                      input logic [4:0] t, input logic [31:0] er, input logic ed, input int el, input int hold);
      int cyc = 0;
      while (!in_ready && cyc < 50) begin
         @(negedge clk);
         cyc++;
      end
      op = o; a = x; b = y; tag = t; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      a = $urandom; b = $urandom; op = 2'($urandom); tag = 5'($urandom);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 100);
      chk({nm, " latency"}, 64'(cyc), 64'(el));
      chk({nm, " result"}, out_result, er);
      chk({nm, " tag"}, out_tag, t);
      chk({nm, " dbz"}, out_dbz, ed);
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         chk({nm, " hold valid"}, out_valid, 1);
         chk({nm, " hold result"}, out_result, er);
         chk({nm, " hold in_ready"}, in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk({nm, " drained"}, out_valid, 0);
   endtask

   vec_t tbl[18];

   initial begin
      logic [31:0] er, x, y;
      logic        ed;
      logic [1:0]  o;
      int          el, seen;

      tbl[0]  = '{2'd1, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 8};
      tbl[1]  = '{2'd3, 32'd100, 32'd7, 5'd4, 32'd2, 1'b0, 8};
      tbl[2]  = '{2'd0, -32'sd7, 32'd2, 5'd5, 32'hFFFFFFFD, 1'b0, 4};
      tbl[3]  = '{2'd2, -32'sd7, 32'd2, 5'd6, 32'hFFFFFFFF, 1'b0, 4};
      tbl[4]  = '{2'd2, 32'd7, -32'sd2, 5'd7, 32'd1, 1'b0, 4};
      tbl[5]  = '{2'd1, 32'h1234, 32'd0, 5'd8, 32'hFFFFFFFF, 1'b1, 1};
      tbl[6]  = '{2'd2, -32'sd5, 32'd0, 5'd9, 32'hFFFFFFFB, 1'b1, 1};
      tbl[7]  = '{2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd10, 32'h80000000, 1'b0, 1};
      tbl[8]  = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 5'd11, 32'h0, 1'b0, 1};
      tbl[9]  = '{2'd1, 32'd3, 32'd10, 5'd12, 32'd0, 1'b0, 1};
      tbl[10] = '{2'd3, 32'd3, 32'd10, 5'd13, 32'd3, 1'b0, 1};
      tbl[11] = '{2'd2, 32'hFFFFFFFD, 32'hFFFFFFF6, 5'd14, 32'hFFFFFFFD, 1'b0, 1};
      tbl[12] = '{2'd0, 32'h80000000, 32'd2, 5'd15, 32'hC0000000, 1'b0, 33};
      tbl[13] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd16, 32'd1, 1'b0, 33};
      tbl[14] = '{2'd3, 32'hFFFFFFFF, 32'd10, 5'd17, 32'd5, 1'b0, 33};
      tbl[15] = '{2'd0, -32'sd100, 32'd7, 5'd18, 32'hFFFFFFF2, 1'b0, 8};
      tbl[16] = '{2'd2, -32'sd100, 32'd7, 5'd19, 32'hFFFFFFFE, 1'b0, 8};
      tbl[17] = '{2'd0, 32'd1, 32'd1, 5'd20, 32'd1, 1'b0, 2};

      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      op = 2'd0; a = '0; b = '0; tag = '0;
      repeat (2) @(posedge clk);
      #1 chk("in_ready in reset", in_ready, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("reset out_valid", out_valid, 0);
      chk("reset out_result", out_result, 0);
      chk("reset out_tag", out_tag, 0);
      chk("reset out_dbz", out_dbz, 0);
      chk("reset in_ready", in_ready, 1);

      foreach (tbl[i])
         run($sformatf("vec%0d", i), tbl[i].o, tbl[i].x, tbl[i].y, tbl[i].t, tbl[i].r, tbl[i].d, tbl[i].lat, 0);

      // Backpressure with a second request already waiting through the drain.
      @(negedge clk);
      op = 2'd1; a = 32'hFFFFFFFF; b = 32'd1; tag = 5'd7; in_valid = 1'b1;
      @(posedge clk);
      #1 op = 2'd1; a = 32'd5; b = 32'd0; tag = 5'd8;
      el = 0;
      do begin
         @(negedge clk);
         el++;
      end while (!out_valid && el < 100);
      chk("bp latency", 64'(el), 33);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("bp valid", out_valid, 1);
         chk("bp result", out_result, 32'hFFFFFFFF);
         chk("bp tag", out_tag, 7);
         chk("bp in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
      chk("bp no accept on drain", out_valid, 0);
      chk("bp in_ready after drain", in_ready, 1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("bp next valid", out_valid, 1);
      chk("bp next result", out_result, 32'hFFFFFFFF);
      chk("bp next tag", out_tag, 8);
      chk("bp next dbz", out_dbz, 1);
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;

      // Flush during CALC.
      @(negedge clk);
      op = 2'd1; a = 32'd1000; b = 32'd3; tag = 5'd9; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (3) @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush in_ready", in_ready, 1);
      seen = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("flush no result", 64'(seen), 0);
      run("after flush", 2'd0, 32'd9, 32'd3, 5'd12, 32'd3, 1'b0, 5, 0);

      // Flush beats a simultaneous accept.
      @(negedge clk);
      op = 2'd1; a = 32'd5; b = 32'd0; tag = 5'd1; in_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush+accept valid", out_valid, 0);
      chk("flush+accept in_ready", in_ready, 1);

      // Flush in DONE drops the held result.
      op = 2'd1; a = 32'd5; b = 32'd0; tag = 5'd2; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("done valid", out_valid, 1);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush done valid", out_valid, 0);
      chk("flush done in_ready", in_ready, 1);

      // Reset mid-operation.
      op = 2'd1; a = 32'd100; b = 32'd7; tag = 5'd21; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("mid rst valid", out_valid, 0);
      chk("mid rst result", out_result, 0);
      chk("mid rst tag", out_tag, 0);
      chk("mid rst in_ready", in_ready, 1);

      for (int i = 0; i < 60; i++) begin
         o = 2'($urandom);
         x = $urandom;
         y = $urandom;
         case ($urandom_range(0, 5))
            0: y = y >> $urandom_range(0, 31);
            1: begin x = $urandom_range(0, 300); y = $urandom_range(1, 20); end
            2: y = '0;
            3: begin x = 32'h80000000; y = 32'hFFFFFFFF; end
            4: begin x = x >> $urandom_range(0, 31); y = $urandom_range(1, 9); end
            default: ;
         endcase
         model(o, x, y, er, ed, el);
         run($sformatf("rnd%0d", i), o, x, y, 5'($urandom), er, ed, el, $urandom_range(0, 3));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
